// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - write/read bundle for the multi-port register file
//
// Purpose: groups the two byte-enabled write ports and the NUM_RD read ports.
// Ports (signals):
//   we0/waddr0/wdata0/wbe0  write port 0 (ALU writeback)
//   we1/waddr1/wdata1/wbe1  write port 1 (load writeback, wins collisions)
//   raddr                   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata                   packed read data, port k at [k*DATA_W +: DATA_W]
// Modports: master drives writes/addresses; slave is the register file.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  localparam int NB = DATA_W / 8;

  logic                     we0;
  logic [ADDR_W-1:0]        waddr0;
  logic [DATA_W-1:0]        wdata0;
  logic [NB-1:0]            wbe0;
  logic                     we1;
  logic [ADDR_W-1:0]        waddr1;
  logic [DATA_W-1:0]        wdata1;
  logic [NB-1:0]            wbe1;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;

  modport master (
    output we0, waddr0, wdata0, wbe0,
    output we1, waddr1, wdata1, wbe1,
    output raddr,
    input  rdata
  );

  modport slave (
    input  we0, waddr0, wdata0, wbe0,
    input  we1, waddr1, wdata1, wbe1,
    input  raddr,
    output rdata
  );
endinterface

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with byte enables and write bypass
//
// Purpose: DEPTH x DATA_W storage, two clocked byte-enabled write ports,
// NUM_RD combinational read ports with same-cycle write-to-read bypass,
// optional hardwired zero entry, asynchronous clear.
// Ports:
//   clk    clock, writes on rising edge
//   reset  asynchronous active-high clear of all entries
//   bus    reg_file_mp_if slave (write ports, read addresses, read data)
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          reset,
  reg_file_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic                     we0;
  logic [ADDR_W-1:0]        waddr0;
  logic [DATA_W-1:0]        wdata0;
  logic [NB-1:0]            wbe0;
  logic                     we1;
  logic [ADDR_W-1:0]        waddr1;
  logic [DATA_W-1:0]        wdata1;
  logic [NB-1:0]            wbe1;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  assign we0       = bus.we0;
  assign waddr0    = bus.waddr0;
  assign wdata0    = bus.wdata0;
  assign wbe0      = bus.wbe0;
  assign we1       = bus.we1;
  assign waddr1    = bus.waddr1;
  assign wdata1    = bus.wdata1;
  assign wbe1      = bus.wbe1;
  assign raddr     = bus.raddr;
  assign bus.rdata = rdata_d;

  // Value entry 'addr' holds after this edge. Used for both the next-state
  // and the read bypass, so a bypassed read always equals the post-edge value.
  // Port 1 is checked first so it wins any byte both ports enable.
  function automatic logic [DATA_W-1:0] post_write(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] res;
    res = stored;
    for (int i = 0; i < NB; i++) begin
      if (we1 && (waddr1 == addr) && wbe1[i]) begin
        res[8*i +: 8] = wdata1[8*i +: 8];
      end else if (we0 && (waddr0 == addr) && wbe0[i]) begin
        res[8*i +: 8] = wdata0[8*i +: 8];
      end
    end
    if ((ZERO_REG != 0) && (addr == '0)) begin
      res = '0;
    end
    return res;
  endfunction

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      mem_d[e] = post_write(ADDR_W'(e), mem_q[e]);
    end
  end

  // Bypass is suppressed under reset so every port reads zero.
  always_comb begin
    rdata_d = '0;
    if (!reset) begin
      for (int k = 0; k < NUM_RD; k++) begin
        rdata_d[k*DATA_W +: DATA_W] =
          post_write(raddr[k*ADDR_W +: ADDR_W], mem_q[raddr[k*ADDR_W +: ADDR_W]]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= mem_d[e];
      end
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp
module tb_reg_file_mp;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifb ();
  reg_file_mp_if #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3)) ifc ();

  // ifb mirrors ifa stimulus; only ZERO_REG differs between dut_a and dut_b.
  assign ifb.we0    = ifa.we0;
  assign ifb.waddr0 = ifa.waddr0;
  assign ifb.wdata0 = ifa.wdata0;
  assign ifb.wbe0   = ifa.wbe0;
  assign ifb.we1    = ifa.we1;
  assign ifb.waddr1 = ifa.waddr1;
  assign ifb.wdata1 = ifa.wdata1;
  assign ifb.wbe1   = ifa.wbe1;
  assign ifb.raddr  = ifa.raddr;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));
  reg_file_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(1)) dut_c (
    .clk(clk), .reset(reset), .bus(ifc));

  // Reference model: current contents and contents after the pending edge.
  logic [31:0] m_a [32];
  logic [31:0] m_b [32];
  logic [31:0] nx_a [32];
  logic [31:0] nx_b [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_a(input int k);
    return ifa.rdata[k*32 +: 32];
  endfunction

  function automatic logic [31:0] rd_b(input int k);
    return ifb.rdata[k*32 +: 32];
  endfunction

  function automatic logic [63:0] rd_c(input int k);
    return ifc.rdata[k*64 +: 64];
  endfunction

  task automatic model_clear();
    for (int e = 0; e < 32; e++) begin
      m_a[e] = '0;
      m_b[e] = '0;
    end
  endtask

  // Apply port 0's bytes, then port 1's on top; zero entry forced in model A.
  task automatic model_next();
    nx_a = m_a;
    nx_b = m_b;
    for (int i = 0; i < 4; i++) begin
      if (ifa.we0 && ifa.wbe0[i]) begin
        nx_a[ifa.waddr0][8*i +: 8] = ifa.wdata0[8*i +: 8];
        nx_b[ifa.waddr0][8*i +: 8] = ifa.wdata0[8*i +: 8];
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (ifa.we1 && ifa.wbe1[i]) begin
        nx_a[ifa.waddr1][8*i +: 8] = ifa.wdata1[8*i +: 8];
        nx_b[ifa.waddr1][8*i +: 8] = ifa.wdata1[8*i +: 8];
      end
    end
    nx_a[0] = '0;
  endtask

  // Check bypassed reads against the model before the edge, then commit.
  task automatic step(input string tag);
    logic [4:0] ra;
    @(negedge clk);
    model_next();
    for (int k = 0; k < 2; k++) begin
      ra = ifa.raddr[k*5 +: 5];
      check({tag, "_a"}, rd_a(k), reset ? 32'h0 : nx_a[ra]);
      check({tag, "_b"}, rd_b(k), reset ? 32'h0 : nx_b[ra]);
    end
    @(posedge clk);
    if (!reset) begin
      m_a = nx_a;
      m_b = nx_b;
    end
    #1;
  endtask

  task automatic idle();
    ifa.we0 = 1'b0;
    ifa.we1 = 1'b0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    ifa.we0 = 1'b1; ifa.waddr0 = a; ifa.wdata0 = d; ifa.wbe0 = be;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    ifa.we1 = 1'b1; ifa.waddr1 = a; ifa.wdata1 = d; ifa.wbe1 = be;
  endtask

  initial begin
    ifa.we0 = 0; ifa.waddr0 = 0; ifa.wdata0 = 0; ifa.wbe0 = 0;
    ifa.we1 = 0; ifa.waddr1 = 0; ifa.wdata1 = 0; ifa.wbe1 = 0;
    ifa.raddr = 0;
    ifc.we0 = 0; ifc.waddr0 = 0; ifc.wdata0 = 0; ifc.wbe0 = 0;
    ifc.we1 = 0; ifc.waddr1 = 0; ifc.wdata1 = 0; ifc.wbe1 = 0;
    ifc.raddr = 0;
    model_clear();

    #1 reset = 1'b1;
    #2;
    check("rst_a", {32'h0, rd_a(0)}, 64'h0);
    check("rst_b", {32'h0, rd_b(1)}, 64'h0);
    for (int k = 0; k < 3; k++) check("rst_c", rd_c(k), 64'h0);
    @(posedge clk); #1 reset = 1'b0;

    // Asynchronous clear without a clock edge.
    wr0(5'd5, 32'hDEADBEEF, 4'hF);
    ifa.raddr = {5'd5, 5'd5};
    step("wr_r5");
    idle(); #1;
    check("r5_pre_rst", rd_a(0), 32'hDEADBEEF);
    reset = 1'b1; #1;
    model_clear();
    check("r5_in_rst_a", rd_a(0), 32'h0);
    check("r5_in_rst_b", rd_b(1), 32'h0);
    @(posedge clk); #1 reset = 1'b0; #1;
    check("r5_post_rst", rd_a(0), 32'h0);

    // Basic write, both read ports on the same entry.
    wr0(5'd3, 32'h12345678, 4'hF);
    ifa.raddr = {5'd3, 5'd3};
    step("basic");
    idle(); #1;
    check("basic_p0", rd_a(0), 32'h12345678);
    check("basic_p1", rd_a(1), 32'h12345678);

    // Partial-byte bypass.
    wr0(5'd7, 32'hAABBCCDD, 4'hF);
    ifa.raddr = {5'd3, 5'd7};
    step("r7_init");
    wr0(5'd7, 32'h11223344, 4'h3); #1;
    check("byp_pre", rd_a(0), 32'hAABB3344);
    step("byp");
    idle(); #1;
    check("byp_post", rd_a(0), 32'hAABB3344);

    // Collision: port 1 wins overlapping bytes.
    wr0(5'd9, 32'h11111111, 4'hF);
    wr1(5'd9, 32'h22222222, 4'hC);
    ifa.raddr = {5'd7, 5'd9}; #1;
    check("coll_pre", rd_a(0), 32'h22221111);
    step("coll");
    idle(); #1;
    check("coll_post", rd_a(0), 32'h22221111);

    // Zero register on dut_a, ordinary entry 0 on dut_b.
    wr0(5'd0, 32'hFFFFFFFF, 4'hF);
    ifa.raddr = {5'd0, 5'd0}; #1;
    check("zero_pre_a", rd_a(0), 32'h0);
    check("zero_pre_b", rd_b(1), 32'hFFFFFFFF);
    step("zero");
    idle(); #1;
    check("zero_post_a", rd_a(1), 32'h0);
    check("zero_post_b", rd_b(0), 32'hFFFFFFFF);

    // Wide configuration: 64-bit data, 16 entries, 3 read ports.
    ifc.we0 = 1'b1; ifc.waddr0 = 4'd15; ifc.wdata0 = 64'h0123456789ABCDEF; ifc.wbe0 = 8'hFF;
    ifc.raddr = {4'd15, 4'd15, 4'd15}; #1;
    for (int k = 0; k < 3; k++) check("c_full_pre", rd_c(k), 64'h0123456789ABCDEF);
    @(posedge clk); #1 ifc.we0 = 1'b0; #1;
    for (int k = 0; k < 3; k++) check("c_full_post", rd_c(k), 64'h0123456789ABCDEF);
    ifc.we0 = 1'b1; ifc.wdata0 = 64'hFEDCBA9876543210; ifc.wbe0 = 8'h80; #1;
    for (int k = 0; k < 3; k++) check("c_b7_pre", rd_c(k), 64'hFE23456789ABCDEF);
    @(posedge clk); #1 ifc.we0 = 1'b0; #1;
    for (int k = 0; k < 3; k++) check("c_b7_post", rd_c(k), 64'hFE23456789ABCDEF);

    // Random traffic on a narrow address range to force collisions/bypass.
    for (int n = 0; n < 400; n++) begin
      ifa.we0    = 1'($urandom_range(0, 1));
      ifa.waddr0 = 5'($urandom_range(0, 7));
      ifa.wdata0 = $urandom;
      ifa.wbe0   = 4'($urandom_range(0, 15));
      ifa.we1    = 1'($urandom_range(0, 1));
      ifa.waddr1 = 5'($urandom_range(0, 7));
      ifa.wdata1 = $urandom;
      ifa.wbe1   = 4'($urandom_range(0, 15));
      ifa.raddr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b1;
        model_clear();
        step("rnd_rst");
        reset = 1'b0;
      end else begin
        step("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the single-cycle register file.
- Provides DEPTH x DATA_W storage with NUM_RD combinational read ports and two clocked write ports, each with byte enables.
- Adds same-cycle write-to-read bypass on every read port, an optional hardwired zero register, and asynchronous clear of all entries.
- Sits in the decode stage, feeding operand muxes; write port 0 serves ALU writeback, write port 1 serves load writeback.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register.

Ports:
- clk  in  1  clock; all writes on rising edge.
- reset  in  1  asynchronous, active-high; clears all entries.
- we0  in  1  write enable, port 0.
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- wbe0  in  DATA_W/8  byte enables, port 0; bit i covers wdata0[8i+7:8i].
- we1  in  1  write enable, port 1.
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- wbe1  in  DATA_W/8  byte enables, port 1.
- raddr  in  NUM_RD*ADDR_W  read addresses; port k = raddr[k*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data; port k = rdata[k*DATA_W +: DATA_W].

Behaviour:
- Reset: while reset=1, every entry is 0 immediately, independent of clk; writes are ignored, and rdata = 0 on all ports once addresses settle (bypass suppressed).
- Deassertion of reset is released synchronously by the integrator; the block needs no extra logic for it.
- Write: on posedge clk with reset=0, for each port p with wep=1, byte i of entry waddrp takes byte i of wdatap where wbep[i]=1; other bytes hold.
- wep=1 with wbep=0 is a no-op.
- Write collision: same waddr on both ports, both enabled, same byte enabled: port 1 wins that byte. Non-overlapping bytes from both ports are applied together.
- Zero register: when ZERO_REG=1, writes to address 0 are dropped and reads of address 0 return 0, including bypass.
- Read: purely combinational, zero latency. Before bypass, rdata_k = mem[raddr_k].
- Bypass: per read port, per byte, result = port-1 data if (we1 & waddr1==raddr_k & wbe1[i]); else port-0 data if (we0 & waddr0==raddr_k & wbe0[i]); else stored byte.
- Bypass precedence therefore matches post-edge contents, so a read returns the value the entry will hold after this edge.
- Read ports are independent: any number may address the same entry with identical results.
- Width rules: no sign extension, no truncation; all ports are exactly DATA_W.
- Entries with X addresses are not required to be handled; the bench keeps addresses known.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, assert reset mid-cycle (no clk edge) -> rdata for raddr=5 reads 0x00000000 immediately; after release, still 0.
- Basic write/read: we0=1, waddr0=3, wdata0=0x12345678, wbe0=0xF; edge; raddr0=3 -> 0x12345678; raddr1=3 simultaneously -> 0x12345678.
- Bypass with byte enables:
  - r7=0xAABBCCDD; same cycle we0=1, waddr0=7, wdata0=0x11223344, wbe0=0x3 -> rdata for raddr=7 reads 0xAABB3344 before the edge.
  - After the edge, r7 holds 0xAABB3344.
- Dual-port collision: r9=0; we0 to r9 with 0x11111111, wbe0=0xF; we1 to r9 with 0x22222222, wbe1=0xC -> bypass and post-edge value are both 0x22221111.
- Zero register:
  - ZERO_REG=1: we0 to r0 with 0xFFFFFFFF, wbe0=0xF -> raddr=0 reads 0 during and after the edge.
  - ZERO_REG=0: same stimulus -> reads 0xFFFFFFFF after the edge.
- Parameter sweep: DATA_W=64, ADDR_W=4, NUM_RD=3 -> full-width write of 0x0123456789ABCDEF to r15 reads identically on all three ports; wbe=0x80 updates only byte 7.
